// File: rtl/mmu_merge_arb.sv
// rtl/mmu_merge_arb.sv - N-port request merge with a single outstanding grant for the MMU request path
//
// Ports:
//   clk          rising-edge system clock
//   rstn         synchronous active-low reset
//   i_drive      per-port request level, held until the matching o_free pulse
//   i_data       packed per-port payloads, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_free       one-cycle completion pulse to the granted port (zero or one-hot)
//   o_driveNext  downstream request, held until i_freeNext
//   o_data       registered payload of the granted port
//   o_grant_id   index of the granted port, valid while o_driveNext is high
//   i_freeNext   downstream accept
//
// Build option: MMU_MERGE_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest-index requester always wins.

module mmu_merge_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_PORTS-1:0]             i_drive,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_data,
    output logic [NUM_PORTS-1:0]             o_free,
    output logic                             o_driveNext,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [ID_WIDTH-1:0]              o_grant_id,
    input  logic                             i_freeNext
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  any_req;
    logic [ID_WIDTH-1:0]   win_id;
    logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];

    // Unpack the flat payload bus so the winner can be picked by index.
    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
            assign data_arr[g] = i_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign any_req = |i_drive;

`ifdef MMU_MERGE_ROUND_ROBIN_EN
    localparam int DW = ID_WIDTH + 1;

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [DW-1:0]       best_dist;
    logic [DW-1:0]       dist;

    // Winner is the requester with the smallest upward distance from the
    // pointer, measured modulo NUM_PORTS so non-power-of-two counts wrap
    // correctly. The sentinel all-ones distance exceeds any real distance.
    always_comb begin
        win_id    = '0;
        best_dist = '1;
        dist      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (DW'(p) >= {1'b0, rr_ptr}) begin
                dist = DW'(p) - {1'b0, rr_ptr};
            end else begin
                dist = DW'(p) + DW'(NUM_PORTS) - {1'b0, rr_ptr};
            end
            if (i_drive[ID_WIDTH'(p)] && (dist < best_dist)) begin
                best_dist = dist;
                win_id    = ID_WIDTH'(p);
            end
        end
    end

    // Pointer moves past the port just served; it only changes in DONE so
    // the grant captured in IDLE always sees a settled value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (state == ST_DONE) begin
            if (o_grant_id == ID_WIDTH'(NUM_PORTS - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= o_grant_id + 1'b1;
            end
        end
    end
`else
    // Fixed priority: scan downward so the lowest requesting index is the
    // last assignment and therefore wins.
    always_comb begin
        win_id = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (i_drive[ID_WIDTH'(p)]) begin
                win_id = ID_WIDTH'(p);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DONE never samples requests: the served port still
    // has its request up during that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_freeNext) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant capture. Payload and id are frozen outside IDLE, which makes a
    // source dropping its request mid-grant harmless.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_data     <= '0;
            o_grant_id <= '0;
        end else if ((state == ST_IDLE) && any_req) begin
            o_data     <= data_arr[win_id];
            o_grant_id <= win_id;
        end
    end

    // Output decode from the registered state; o_free is one-hot by
    // construction since it is a shift of a single bit.
    always_comb begin
        o_driveNext = (state == ST_BUSY);
        o_free      = '0;
        if (state == ST_DONE) begin
            o_free = NUM_PORTS'(1) << o_grant_id;
        end
    end

endmodule

// File: tb/tb_mmu_merge_arb.sv
// tb/tb_mmu_merge_arb.sv - directed vector bench for mmu_merge_arb (4-port and 3-port instances)

module tb_mmu_merge_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic [3:0]   drv4;
    logic [511:0] dat4;
    logic         fn4;
    logic [3:0]   free4;
    logic         dn4;
    logic [127:0] odat4;
    logic [1:0]   gid4;

    logic [2:0]   drv3;
    logic [23:0]  dat3;
    logic         fn3;
    logic [2:0]   free3;
    logic         dn3;
    logic [7:0]   odat3;
    logic [1:0]   gid3;

    mmu_merge_arb #(.NUM_PORTS(4), .DATA_WIDTH(128), .ID_WIDTH(2)) u4 (
        .clk         (clk),
        .rstn        (rstn),
        .i_drive     (drv4),
        .i_data      (dat4),
        .o_free      (free4),
        .o_driveNext (dn4),
        .o_data      (odat4),
        .o_grant_id  (gid4),
        .i_freeNext  (fn4)
    );

    mmu_merge_arb #(.NUM_PORTS(3), .DATA_WIDTH(8), .ID_WIDTH(2)) u3 (
        .clk         (clk),
        .rstn        (rstn),
        .i_drive     (drv3),
        .i_data      (dat3),
        .o_free      (free3),
        .o_driveNext (dn3),
        .o_data      (odat3),
        .o_grant_id  (gid3),
        .i_freeNext  (fn3)
    );

`ifdef MMU_MERGE_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic         rstn;
        logic [3:0]   drive;
        logic         fn;
        logic         exp_dn;
        logic [3:0]   exp_free;
        logic [1:0]   exp_gid;
        logic [127:0] exp_data;
    } vec_t;

    vec_t         vecs [12];
    logic [127:0] pd [4];
    logic [1:0]   exp_seq [6];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer on the 3-port instance, downstream accepting at once.
    task automatic xfer3(input logic [2:0] d, input logic [1:0] e, input string tag);
        drv3 = d;
        fn3  = 1'b1;
        step();
        chk({tag, " dn"}, 128'(dn3), 128'd1);
        chk({tag, " gid"}, 128'(gid3), 128'(e));
        chk({tag, " data"}, 128'(odat3), 128'(8'h50 + 8'(e)));
        step();
        chk({tag, " free"}, 128'(free3), 128'(3'b001 << e));
        step();
    endtask

    initial begin
        int k;
        int last;

        pd[0] = {16{8'h10}};
        pd[1] = {16{8'h21}};
        pd[2] = {16{8'hA5}};
        pd[3] = {16{8'h3C}};

        rstn = 1'b0;
        drv4 = '0;
        fn4  = 1'b0;
        dat4 = {pd[3], pd[2], pd[1], pd[0]};
        drv3 = '0;
        fn3  = 1'b0;
        dat3 = {8'h52, 8'h51, 8'h50};

        //             rstn  drive    fn    dn    free     gid   data
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 128'd0};
        vecs[1]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, pd[2]};
        vecs[2]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, pd[2]};
        vecs[3]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, pd[2]};
        vecs[4]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, pd[2]};
        vecs[5]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, pd[2]};
        vecs[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, pd[2]};
        vecs[7]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, pd[2]};
        vecs[8]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, pd[2]};
        vecs[9]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, pd[3]};
        vecs[10] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, pd[3]};
        vecs[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, pd[3]};

        for (int i = 0; i < 12; i++) begin
            rstn = vecs[i].rstn;
            drv4 = vecs[i].drive;
            fn4  = vecs[i].fn;
            step();
            chk($sformatf("vec%0d dn", i), 128'(dn4), 128'(vecs[i].exp_dn));
            chk($sformatf("vec%0d free", i), 128'(free4), 128'(vecs[i].exp_free));
            chk($sformatf("vec%0d gid", i), 128'(gid4), 128'(vecs[i].exp_gid));
            chk($sformatf("vec%0d data", i), odat4, vecs[i].exp_data);
        end

        // Backpressure: grant port 1, hold i_freeNext low for 10 cycles.
        drv4 = 4'b0010;
        fn4  = 1'b0;
        step();
        chk("bp grant", 128'({dn4, gid4, free4}), 128'({1'b1, 2'd1, 4'b0000}));
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("bp hold%0d", c), 128'({dn4, gid4, free4}), 128'({1'b1, 2'd1, 4'b0000}));
            chk($sformatf("bp data%0d", c), odat4, pd[1]);
        end
        fn4 = 1'b1;
        step();
        chk("bp free", 128'({dn4, free4}), 128'({1'b0, 4'b0010}));
        drv4 = 4'b0000;
        fn4  = 1'b0;
        step();
        chk("bp idle", 128'({dn4, free4}), 128'd0);

        // Reset in the middle of a grant to port 2.
        drv4 = 4'b0100;
        step();
        chk("rst grant", 128'({dn4, gid4}), 128'({1'b1, 2'd2}));
        rstn = 1'b0;
        step();
        chk("rst outs", 128'({dn4, gid4, free4}), 128'd0);
        chk("rst data", odat4, 128'd0);
        rstn = 1'b1;
        step();
        chk("rst regrant", 128'({dn4, gid4, free4}), 128'({1'b1, 2'd2, 4'b0000}));
        fn4 = 1'b1;
        step();
        chk("rst free", 128'(free4), 128'(4'b0100));
        drv4 = 4'b0000;
        fn4  = 1'b0;
        step();

        // All four ports requesting continuously from a fresh reset.
        if (RR) begin
            exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        end else begin
            exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        drv4 = 4'b1111;
        fn4  = 1'b1;
        k    = 0;
        last = 0;
        for (int e = 1; e <= 18; e++) begin
            step();
            if (free4 != 4'b0000) begin
                chk("all onehot", 128'($onehot(free4)), 128'd1);
                if (k < 6) begin
                    chk($sformatf("all order%0d", k), 128'(free4), 128'(4'b0001 << exp_seq[k]));
                end
                if (k > 0) begin
                    chk($sformatf("all spacing%0d", k), 128'(e - last), 128'd3);
                end
                last = e;
                k++;
            end
        end
        chk("all count", 128'(k), 128'd6);
        drv4 = 4'b1110;
        step();
        chk("drop0 gid", 128'({dn4, gid4}), 128'({1'b1, (RR ? 2'd2 : 2'd1)}));
        step();
        chk("drop0 free", 128'(free4), 128'(RR ? 4'b0100 : 4'b0010));
        drv4 = 4'b0000;
        fn4  = 1'b0;
        step();

        // Three-port instance: pointer wraps from 2 back to 0.
        xfer3(3'b010, 2'd1, "p3 a");
        xfer3(3'b011, 2'd0, "p3 b");
        xfer3(3'b011, (RR ? 2'd1 : 2'd0), "p3 c");
        xfer3(3'b011, 2'd0, "p3 d");
        xfer3(3'b100, 2'd2, "p3 e");
        xfer3(3'b110, 2'd1, "p3 f");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_merge_arb.md
Name: mmu_merge_arb

Overview:
- Synchronous N-port request merge for the MMU request path.
- Collects drive/data requests from NUM_PORTS sources and grants exactly one at a time.
- Registers the granted payload and presents it downstream with a drive/free handshake.
- Returns a one-cycle free pulse to the winning source once downstream has accepted.

Parameters:
- NUM_PORTS, 4, number of request sources (2..16).
- DATA_WIDTH, 128, payload width per port.
- ID_WIDTH, 2, width of o_grant_id; must equal clog2(NUM_PORTS), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- i_drive  input  NUM_PORTS  per-port request level; bit i is held high until o_free[i] pulses.
- i_data  input  NUM_PORTS*DATA_WIDTH  packed payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while i_drive[i] is high.
- o_free  output  NUM_PORTS  one-cycle completion pulse to the granted port.
- o_driveNext  output  1  downstream request; held high until accepted.
- o_data  output  DATA_WIDTH  registered payload of the granted port.
- o_grant_id  output  ID_WIDTH  index of the port currently granted; valid while o_driveNext is high.
- i_freeNext  input  1  downstream accept; a transfer completes on a cycle where o_driveNext and i_freeNext are both high.

Behaviour:
- Reset (rstn low at a clock edge):
  - State goes to IDLE.
  - o_driveNext=0, o_free=0, o_data=0, o_grant_id=0.
  - Round-robin pointer=0.
  - Reset overrides every state, including mid-transfer. No o_free is issued for an aborted grant. The source must re-request after reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any i_drive bit is high, select winner w (rules below).
  - Capture i_data[w] into o_data and w into o_grant_id.
  - Set o_driveNext=1 and go to BUSY.
  - Request-to-o_driveNext latency is 1 cycle.
  - If no bit is high, remain in IDLE; o_data and o_grant_id hold their previous values.
- BUSY:
  - o_driveNext stays high; o_data and o_grant_id are frozen.
  - On i_freeNext=1: clear o_driveNext, assert o_free[w] for the next cycle, and go to DONE.
  - i_freeNext arriving in the same cycle o_driveNext rises is legal and completes the transfer.
  - i_freeNext while not in BUSY is ignored.
- DONE:
  - o_free[w]=1 for exactly this one cycle.
  - Update the pointer to (w+1) mod NUM_PORTS.
  - Return to IDLE.
  - Requests are not sampled in DONE, because i_drive[w] is still high this cycle.
- Minimum issue interval: 3 cycles per transfer when downstream accepts immediately.
- Protocol violations:
  - Dropping i_drive[w] while granted has no effect; the payload is already registered and the transfer completes normally.
  - Changing i_data of a non-granted port is permitted.
- Mutual exclusion invariants:
  - o_free is zero or one-hot at all times.
  - Never more than one outstanding grant.
- Simultaneous requests: exactly one winner per IDLE cycle. The losers remain pending and are evaluated at the next IDLE.
- Pointer arithmetic wraps modulo NUM_PORTS; a non-power-of-two NUM_PORTS must wrap at NUM_PORTS-1 to 0.

Optional Feature:
- Macro: MMU_MERGE_ROUND_ROBIN_EN.
- Defined: the winner is the first requesting port at or after the pointer, searching upward with wrap. The pointer advances in DONE as described above.
- Undefined:
  - Fixed priority: the lowest-index requesting port always wins.
  - The pointer register is not implemented.
  - o_grant_id and all other timing are unchanged.

Test Plan:
- Reset mid-transfer: grant port 2 (o_driveNext=1, o_grant_id=2), pull rstn low for 1 cycle -> all outputs 0 next cycle, o_free[2] never pulses, IDLE re-grants port 2 one cycle after rstn high.
- Single request, NUM_PORTS=4: i_drive=4'b0100, i_data[2]=128'hA5.., i_freeNext tied high -> o_driveNext high at cycle 1 with o_data=128'hA5.., o_grant_id=2; o_free=4'b0100 for one cycle at cycle 2; a held request is re-granted at cycle 4.
- Backpressure: i_freeNext held low for 10 cycles after grant -> o_driveNext, o_data and o_grant_id stable for all 10 cycles; o_free stays 0 until the cycle after i_freeNext rises.
- All four ports requesting continuously, round-robin enabled -> grant order 0,1,2,3,0,1; each o_free pulse is one-hot and exactly 3 cycles apart.
- Same traffic with MMU_MERGE_ROUND_ROBIN_EN undefined -> port 0 wins every arbitration while held. Drop i_drive[0] -> port 1 wins next.
- NUM_PORTS=3 round-robin: pointer at 2, requests on ports 0 and 1 -> port 0 wins (wrap), then port 1.
